// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory/device bus arbiter.
// Holds the FSM encoding and the address map.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_DEV_WAIT = 2'd2
    } arb_state_t;

    localparam logic [31:0] DM_TOP    = 32'h0000_3000;
    localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV0_TOP  = 32'h0000_7F0B;
    localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;
    localparam logic [31:0] DEV1_TOP  = 32'h0000_7F1B;

    // Word offset (addr[3:2]) of the read-only timer count register
    localparam logic [1:0] TMR_CNT_OFS = 2'b10;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder for the data bus.
// Flags DM/device hits and any access that must complete with an error.
module mem_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_TOP = mem_bus_arbiter_pkg::DM_TOP
) (
    input  logic [31:0] i_addr,
    input  logic        i_we,
    output logic        o_hit_dm,
    output logic        o_hit_dev,
    output logic        o_err
);

    logic w_misal;
    logic w_dev0;
    logic w_dev1;
    logic w_cnt_wr;

    // Region match, alignment and read-only register protection
    always_comb begin
        w_misal   = |i_addr[1:0];
        w_dev0    = (i_addr >= DEV0_BASE) && (i_addr <= DEV0_TOP);
        w_dev1    = (i_addr >= DEV1_BASE) && (i_addr <= DEV1_TOP);
        o_hit_dm  = i_addr < DM_TOP;
        o_hit_dev = w_dev0 | w_dev1;
        w_cnt_wr  = o_hit_dev & i_we & (i_addr[3:2] == TMR_CNT_OFS);
        o_err     = w_misal | ~(o_hit_dm | o_hit_dev) | w_cnt_wr;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory/device bus.
// Single-cycle DM accesses, fixed wait states for device accesses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned DEV_WAIT = 2,
    parameter logic [31:0] DM_TOP   = mem_bus_arbiter_pkg::DM_TOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m1_wd,
    output logic [1:0]  m_ready,
    output logic [1:0]  m_err,
    output logic [31:0] m_rd,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd,
    output logic        pr_we,
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wd,
    input  logic [31:0] pr_rd
);

    localparam logic [2:0] LP_WAIT = 3'(DEV_WAIT);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_last_gnt;
    logic        r_gnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wd;
    logic [2:0]  r_cnt;

    logic        w_win;
    logic        w_hit_dm;
    logic        w_hit_dev;
    logic        w_err;
    logic        w_dm_ok;
    logic        w_dev_ok;
    logic        w_load_cnt;

    mem_addr_decode #(
        .DM_TOP   (DM_TOP)
    ) u_dec (
        .i_addr   (r_addr),
        .i_we     (r_we),
        .o_hit_dm (w_hit_dm),
        .o_hit_dev(w_hit_dev),
        .o_err    (w_err)
    );

    // Round-robin pick: on contention the master not granted last wins
    always_comb begin
        w_win = (m_req == 2'b11) ? ~r_last_gnt : m_req[1];
    end

    // State, grant and request latch; counter reloads on device access
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wd       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && |m_req) begin
                r_gnt      <= w_win;
                r_last_gnt <= w_win;
                r_addr     <= w_win ? m1_addr : m0_addr;
                r_wd       <= w_win ? m1_wd : m0_wd;
                r_we       <= m_we[w_win];
            end
            if (w_load_cnt) begin
                r_cnt <= LP_WAIT;
            end else if (r_state == ST_DEV_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Next state, slave strobes and the response to the granted master
    always_comb begin
        w_state_nxt = r_state;
        w_load_cnt  = 1'b0;
        w_dm_ok     = w_hit_dm & ~w_err;
        w_dev_ok    = w_hit_dev & ~w_err;
        m_ready     = '0;
        m_err       = '0;
        m_rd        = '0;
        dm_we       = 1'b0;
        pr_we       = 1'b0;
        dm_addr     = '0;
        dm_wd       = '0;
        pr_addr     = '0;
        pr_wd       = '0;
        if (r_state != ST_IDLE) begin
            dm_addr = r_addr;
            dm_wd   = r_wd;
            pr_addr = r_addr;
            pr_wd   = r_wd;
        end
        case (r_state)
            ST_IDLE: begin
                if (|m_req) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                unique case (1'b1)
                    w_err: begin
                        m_ready[r_gnt] = 1'b1;
                        m_err[r_gnt]   = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                    w_dm_ok: begin
                        dm_we          = r_we;
                        m_ready[r_gnt] = 1'b1;
                        m_rd           = dm_rd;
                        w_state_nxt    = ST_IDLE;
                    end
                    w_dev_ok: begin
                        pr_we       = r_we;
                        w_load_cnt  = 1'b1;
                        w_state_nxt = ST_DEV_WAIT;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
            ST_DEV_WAIT: begin
                if (r_cnt == 3'd1) begin
                    m_ready[r_gnt] = 1'b1;
                    m_rd           = pr_rd;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: master agents, DM/device models and a
// transaction-schedule reference checked every cycle.
module tb_mem_bus_arbiter;

    localparam int          DW     = 2;
    localparam logic [31:0] PR_KEY = 32'h0000_6D30;

    typedef enum {K_DM, K_DEV, K_ERR} kind_e;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        bit          drop;
    } rq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_we = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wd = '0, m1_wd = '0;
    logic [1:0]  m_ready, m_err;
    logic [31:0] m_rd;
    logic        dm_we, pr_we;
    logic [31:0] dm_addr, dm_wd, dm_rd;
    logic [31:0] pr_addr, pr_wd, pr_rd;

    mem_bus_arbiter #(.DEV_WAIT(DW)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wd(m0_wd), .m1_wd(m1_wd),
        .m_ready(m_ready), .m_err(m_err), .m_rd(m_rd),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd),
        .pr_we(pr_we), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_rd(pr_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] dm_mem [0:3071];
    logic [31:0] shadow [0:3071];

    always_comb begin
        dm_rd = '0;
        if (dm_addr < 32'h3000) dm_rd = dm_mem[dm_addr[13:2]];
    end

    assign pr_rd = pr_addr ^ PR_KEY;

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit rst_drv = 1'b0;

    // reference: the single in-flight transaction as a cycle schedule
    int t_start = -1, t_done = -1;
    bit last = 1'b1;
    bit g = 1'b0;
    kind_e kind = K_ERR;
    logic [31:0] x_addr, x_wd, x_rd;
    logic x_we;

    // agents
    rq_t q0[$], q1[$];
    rq_t cur[2];
    bit act[2], first[2];
    logic [1:0] seen = '0;
    int got[2], rdy_cyc[2], start_cyc[2], err_obs = 0;
    logic [31:0] last_rd[2];
    int rdy_log[$], rdy_cyc_log[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic kind_e classify(logic [31:0] a, logic w);
        if (a % 4 != 0) return K_ERR;
        if (a < 32'h3000) return K_DM;
        if ((a >= 32'h7F00 && a <= 32'h7F0B) ||
            (a >= 32'h7F10 && a <= 32'h7F1B))
            return (w && ((a / 4) % 4 == 2)) ? K_ERR : K_DEV;
        return K_ERR;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 32'($urandom_range(0, 31) * 4);
            2:       return 32'h2FF0 + 32'($urandom_range(0, 7) * 4);
            3:       return 32'h7F00 + 32'($urandom_range(0, 8) * 4);
            4:       return 32'h7F00 + 32'($urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    task automatic push(int m, logic [31:0] a, logic w,
                        logic [31:0] d, bit drop = 1'b0);
        rq_t r;
        r = '{addr: a, we: w, wd: d, drop: drop};
        if (m == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic check_cycle();
        logic [1:0] er;
        bit in_t;
        in_t = (n >= t_start) && (n <= t_done);
        er = (n == t_done) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("m_ready", 32'(m_ready), 32'(er));
        chk("m_err", 32'(m_err), (kind == K_ERR) ? 32'(er) : 32'h0);
        chk("dm_we", 32'(dm_we),
            32'(n == t_start && kind == K_DM && x_we));
        chk("pr_we", 32'(pr_we),
            32'(n == t_start && kind == K_DEV && x_we));
        chk("dm_addr", dm_addr, in_t ? x_addr : 32'h0);
        chk("dm_wd", dm_wd, in_t ? x_wd : 32'h0);
        chk("pr_addr", pr_addr, in_t ? x_addr : 32'h0);
        chk("pr_wd", pr_wd, in_t ? x_wd : 32'h0);
        if (er == 2'b00) chk("m_rd_idle", m_rd, 32'h0);
        else if (kind != K_ERR && !x_we) chk("m_rd", m_rd, x_rd);
    endtask

    task automatic model_step();
        if (!reset) begin
            t_start = -1;
            t_done  = -1;
            last    = 1'b1;
        end else if (n > t_done && m_req != 2'b00) begin
            g      = (m_req == 2'b11) ? !last : m_req[1];
            last   = g;
            x_addr = g ? m1_addr : m0_addr;
            x_wd   = g ? m1_wd : m0_wd;
            x_we   = m_we[g];
            kind   = classify(x_addr, x_we);
            t_start = n + 1;
            t_done  = t_start + ((kind == K_DEV) ? DW : 0);
            x_rd = '0;
            if (kind == K_DM) begin
                if (x_we) shadow[x_addr / 4] = x_wd;
                else x_rd = shadow[x_addr / 4];
            end
            if (kind == K_DEV) x_rd = x_addr ^ PR_KEY;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        reset = rst_drv;
        for (int i = 0; i < 2; i++) begin
            if (act[i] && seen[i]) act[i] = 1'b0;
            first[i] = 1'b0;
            if (!act[i] && rst_drv) begin
                if (i == 0 && q0.size() > 0) begin
                    cur[0] = q0.pop_front();
                    act[0] = 1'b1;
                    first[0] = 1'b1;
                end
                if (i == 1 && q1.size() > 0) begin
                    cur[1] = q1.pop_front();
                    act[1] = 1'b1;
                    first[1] = 1'b1;
                end
                if (first[i]) start_cyc[i] = n;
            end
        end
        for (int i = 0; i < 2; i++) begin
            bit late;
            late = cur[i].drop && !first[i];
            m_req[i] = act[i] && (!cur[i].drop || first[i]);
            m_we[i]  = act[i] ? (late ? ~cur[i].we : cur[i].we) : 1'b0;
        end
        m0_addr = act[0] ? ((cur[0].drop && !first[0]) ? $urandom : cur[0].addr) : '0;
        m1_addr = act[1] ? ((cur[1].drop && !first[1]) ? $urandom : cur[1].addr) : '0;
        m0_wd   = act[0] ? ((cur[0].drop && !first[0]) ? $urandom : cur[0].wd) : '0;
        m1_wd   = act[1] ? ((cur[1].drop && !first[1]) ? $urandom : cur[1].wd) : '0;
        @(negedge clk);
        if (n >= 1) check_cycle();
        seen = m_ready;
        for (int i = 0; i < 2; i++) begin
            if (m_ready[i]) begin
                got[i]++;
                rdy_cyc[i] = n;
                last_rd[i] = m_rd;
                rdy_log.push_back(i);
                rdy_cyc_log.push_back(n);
                if (m_err[i]) err_obs++;
            end
        end
        if (dm_we && dm_addr < 32'h3000) dm_mem[dm_addr[13:2]] = dm_wd;
        model_step();
        if (!rst_drv) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
            q0.delete();
            q1.delete();
            seen = '0;
        end
        n++;
    endtask

    task automatic drain(string tag);
        int b;
        b = 0;
        do begin
            cycle();
            b++;
        end while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] ||
                    n <= t_done) && b < 2000);
        checks++;
        assert (b < 2000) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d expected<2000", tag, b);
        end
    endtask

    initial begin
        int e0, g0;
        for (int i = 0; i < 3072; i++) begin
            dm_mem[i] = '0;
            shadow[i] = '0;
        end
        act[0] = 1'b0; act[1] = 1'b0;
        got[0] = 0; got[1] = 0;
        rst_drv = 1'b0;
        cycle();
        cycle();
        rst_drv = 1'b1;

        // DM write then read from M0
        push(0, 32'h10, 1'b1, 32'hDEADBEEF);
        push(0, 32'h10, 1'b0, 32'h0);
        drain("t1");
        chk("t1_rd", last_rd[0], 32'hDEADBEEF);
        chk("t1_lat", 32'(rdy_cyc[0] - start_cyc[0]), 32'd1);

        // device read from M1
        push(1, 32'h7F04, 1'b0, 32'h0);
        drain("t2");
        chk("t2_rd", last_rd[1], 32'h1234);
        chk("t2_lat", 32'(rdy_cyc[1] - start_cyc[1]), 32'(1 + DW));

        // error responses
        e0 = err_obs;
        push(0, 32'h4000, 1'b0, 32'h0);
        push(0, 32'h0012, 1'b1, 32'h11112222);
        push(1, 32'h7F08, 1'b1, 32'h33334444);
        drain("t4");
        chk("t4_errs", 32'(err_obs - e0), 32'd3);

        // reset in the first wait cycle of a device read
        push(1, 32'h7F14, 1'b0, 32'h0);
        for (int k = 0; k < 20 && (n - 1) != t_start; k++) cycle();
        rst_drv = 1'b0;
        cycle();
        rst_drv = 1'b1;
        g0 = got[1];
        repeat (4) cycle();
        chk("t5_no_rdy", 32'(got[1] - g0), 32'd0);

        // contention: both masters keep requesting DM
        rdy_log.delete();
        rdy_cyc_log.delete();
        for (int k = 0; k < 3; k++) begin
            push(0, 32'h100 + 32'(8 * k), 1'b0, 32'h0);
            push(1, 32'h200 + 32'(8 * k), 1'b0, 32'h0);
        end
        drain("t3");
        chk("t3_n", 32'(rdy_log.size()), 32'd6);
        if (rdy_log.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("t3_order", 32'(rdy_log[k]), 32'(k % 2));
            for (int k = 0; k < 5; k++)
                chk("t3_gap", 32'(rdy_cyc_log[k + 1] - rdy_cyc_log[k]), 32'd2);
        end

        // M1 drops req right after grant of a device write
        g0 = got[1];
        push(1, 32'h7F00, 1'b1, 32'hCAFE0001, 1'b1);
        drain("t6");
        chk("t6_rdy", 32'(got[1] - g0), 32'd1);
        chk("t6_lat", 32'(rdy_cyc[1] - start_cyc[1]), 32'(1 + DW));

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0)
                push(0, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            if (q1.size() == 0 && $urandom_range(0, 2) == 0)
                push(1, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            cycle();
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the shared data-memory/device bus between two masters.
- M0 is the CPU memory-stage port. M1 is the debug/loader port.
- Decodes each address to DM (0x0000-0x2FFF), timer device window (0x7F00-0x7F0B, 0x7F10-0x7F1B) or unmapped.
- Sequences the access: single-cycle for DM, fixed wait states for devices. Returns a one-cycle ready/err response to the granted master.

Parameters:
- DEV_WAIT, 2, extra wait cycles for a device access (1..7)
- DM_TOP, 32'h3000, first address above DM

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- m_req  in  2  per-master request, bit i = master i
- m_we  in  2  per-master write enable
- m0_addr, m1_addr  in  32  byte address, word access only
- m0_wd, m1_wd  in  32  write data
- m_ready  out  2  one-cycle completion pulse per master
- m_err  out  2  one-cycle error pulse, coincident with m_ready
- m_rd  out  32  read data, valid only while m_ready bit is high
- dm_we  out  1  DM write strobe
- dm_addr  out  32  DM address
- dm_wd  out  32  DM write data
- dm_rd  in  32  DM combinational read data
- pr_we  out  1  device write strobe
- pr_addr  out  32  device address
- pr_wd  out  32  device write data
- pr_rd  in  32  device read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low; sampled on the rising clk edge while reset==0.
- Reset values: state=IDLE, last_gnt=1 (so M0 wins the first contention), wait counter=0. All outputs 0.
- States:
  - IDLE: if any m_req bit is set, latch the winner index, its addr, we and wd, then go to ACCESS.
  - ACCESS: decode the latched address.
    - DM hit, aligned: dm_we=latched we for this cycle only; m_ready[g]=1; m_rd=dm_rd; next state IDLE.
    - Device hit, aligned: pr_we=latched we for this cycle only; counter loads DEV_WAIT; next state DEV_WAIT.
    - Unmapped or addr[1:0]!=0: m_ready[g]=1, m_err[g]=1, no strobe asserted, next state IDLE.
    - Store to timer count register (addr[3:2]==2'b10 in the device window): treated as an error with no strobe.
  - DEV_WAIT: counter decrements each cycle. pr_addr and pr_wd are held; pr_we=0. When the counter reaches 1: m_ready[g]=1, m_rd=pr_rd, next state IDLE.
- Latency:
  - DM: request sampled in IDLE at edge t; ready in cycle t+1.
  - Device: ready at t+1+DEV_WAIT.
  - There is always one IDLE bubble between transactions.
- Arbitration: round-robin. When both masters request in IDLE, grant the master != last_gnt. last_gnt updates on every grant. A single requester is always granted.
- Handshake:
  - A master holds req, we, addr and wd stable until it sees its m_ready.
  - The request is committed at grant. If req deasserts mid-transaction, the access still completes and ready still pulses.
  - A master must not start a new request in the cycle its ready pulses.
- Slave outputs: dm_addr, dm_wd, pr_addr and pr_wd are driven from the latched request while not in IDLE, and are 0 in IDLE. A strobe is never asserted outside ACCESS.
- m_rd is 0 whenever no ready bit is set. m_ready is one-hot or zero.
- Reset mid-transaction: abort immediately to IDLE. No ready pulse and no strobe in the cycle after reset.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ACCESS, DEV_WAIT)
  - address map constants: DM_TOP, DEV0_BASE=0x7F00, DEV0_TOP=0x7F0B, DEV1_BASE=0x7F10, DEV1_TOP=0x7F1B
  - timer count register offset
- One sub-module: mem_addr_decode. Purely combinational; takes addr and we, returns hit_dm, hit_dev, err. It is reused later by the M-stage exception logic.

Test Plan:
- DM write then read: M0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> dm_we pulses exactly one cycle, m_ready[0] one cycle after each req, m_rd=0xDEADBEEF.
- Device read with DEV_WAIT=2: M1 reads 0x7F04 with pr_rd=0x1234 -> pr_we never set, m_ready[1] three cycles after req sampled, m_rd=0x1234.
- Contention: both masters request DM continuously from reset -> grants alternate M0, M1, M0, M1; each ready is 2 cycles apart per transaction.
- Errors: read of 0x4000, write of 0x0012, and write of 0x7F08 -> m_ready=m_err=1 for the requester, dm_we=pr_we=0 throughout.
- Reset mid-access: reset=0 asserted during DEV_WAIT -> next cycle state IDLE, all outputs 0, no ready pulse. After release, M0 wins first contention.
- Req dropped after grant: M1 deasserts req in ACCESS of a device write -> pr_we was pulsed once and m_ready[1] still pulses at the normal cycle.
